// File: rtl/retry_reorder_end_pkg.sv
// Shared types and helpers for the retry reorder stage.
// Holds the ID width defaults, the retry request record and the buffer depth helper.
package retry_reorder_end_pkg;

    localparam int unsigned DefaultIdSize = 4;

    typedef struct packed {
        logic [DefaultIdSize-1:0] id;
    } retry_req_t;

    function automatic int unsigned buffer_depth(input int unsigned id_size);
        return 32'd1 << id_size;
    endfunction

endpackage

// File: rtl/retry_reorder_end_if.sv
// Handshake bundle between time_DMR_end, the reorder stage, its consumer and retry_start.
// The slave modport is the reorder stage; the master modport is its environment.
interface retry_reorder_end_if
    import retry_reorder_end_pkg::*;
#(
    parameter type         DataType = logic,
    parameter int unsigned IDSize   = DefaultIdSize
) ();

    DataType           data_i;
    logic [IDSize-1:0] id_i;
    logic              needs_retry_i;
    logic              valid_i;
    logic              ready_o;

    DataType           data_o;
    logic              valid_o;
    logic              ready_i;

    logic [IDSize-1:0] retry_id_o;
    logic              retry_valid_o;
    logic              retry_ready_i;

    logic              duplicate_o;
    logic [IDSize:0]   occupancy_o;

    modport slave (
        input  data_i, id_i, needs_retry_i, valid_i, ready_i, retry_ready_i,
        output ready_o, data_o, valid_o, retry_id_o, retry_valid_o, duplicate_o, occupancy_o
    );

    modport master (
        output data_i, id_i, needs_retry_i, valid_i, ready_i, retry_ready_i,
        input  ready_o, data_o, valid_o, retry_id_o, retry_valid_o, duplicate_o, occupancy_o
    );

endinterface

// File: rtl/retry_reorder_end_retry_req_reg.sv
// One-entry registered holding stage for retry requests.
// The output is purely registered; only the upstream ready depends on the downstream ready.
module retry_req_reg
    import retry_reorder_end_pkg::*;
#(
    parameter type ReqType = retry_req_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   valid_i,
    output logic   ready_o,
    input  ReqType req_i,
    output logic   valid_o,
    input  logic   ready_i,
    output ReqType req_o
);

    logic   valid_q;
    ReqType req_q;

    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign req_o   = req_q;

    // A refill in the same cycle as a drain wins, keeping the register full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else if (valid_i && ready_o) begin
            valid_q <= 1'b1;
            req_q   <= req_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/retry_reorder_end.sv
// Reorder buffer after time_DMR_end: faulty IDs go back to retry_start,
// good results are parked by ID and released strictly in ID order.
module retry_reorder_end
    import retry_reorder_end_pkg::*;
#(
    parameter type         DataType = logic,
    parameter int unsigned IDSize   = DefaultIdSize
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    retry_reorder_end_if.slave bus
);

    localparam int unsigned Depth = buffer_depth(IDSize);

    typedef struct packed {
        logic [IDSize-1:0] id;
    } req_t;

    DataType           slot_data [Depth];
    logic [Depth-1:0]  slot_valid;
    logic [IDSize-1:0] out_ptr;
    logic [IDSize:0]   occupancy_q;
    logic              duplicate_q;

    logic good_in, faulty_in, store, duplicate, pop;
    logic retry_in_ready, retry_valid;
    req_t retry_in_req, retry_out_req;

    assign good_in   = bus.valid_i && !bus.needs_retry_i;
    assign faulty_in = bus.valid_i && bus.needs_retry_i;
    assign store     = good_in && !slot_valid[bus.id_i];
    assign duplicate = good_in && slot_valid[bus.id_i];
    assign pop       = slot_valid[out_ptr] && bus.ready_i;

    assign bus.ready_o     = !bus.needs_retry_i || retry_in_ready;
    assign bus.valid_o     = slot_valid[out_ptr];
    assign bus.data_o      = slot_data[out_ptr];
    assign bus.duplicate_o = duplicate_q;
    assign bus.occupancy_o = occupancy_q;

    assign retry_in_req.id = bus.id_i;
    assign bus.retry_id_o    = retry_out_req.id;
    assign bus.retry_valid_o = retry_valid;

    retry_req_reg #(
        .ReqType (req_t)
    ) u_retry_req_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (faulty_in),
        .ready_o (retry_in_ready),
        .req_i   (retry_in_req),
        .valid_o (retry_valid),
        .ready_i (bus.retry_ready_i),
        .req_o   (retry_out_req)
    );

    // Payload storage carries no reset; a slot is only read once its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (store) begin
            slot_data[bus.id_i] <= bus.data_i;
        end
    end

    // A store never targets the slot being popped: popping needs it full, storing needs it empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid  <= '0;
            out_ptr     <= '0;
            occupancy_q <= '0;
            duplicate_q <= 1'b0;
        end else begin
            if (pop) begin
                slot_valid[out_ptr] <= 1'b0;
                out_ptr             <= out_ptr + 1'b1;
            end
            if (store) begin
                slot_valid[bus.id_i] <= 1'b1;
            end
            case ({store, pop})
                2'b10:   occupancy_q <= occupancy_q + 1'b1;
                2'b01:   occupancy_q <= occupancy_q - 1'b1;
                default: occupancy_q <= occupancy_q;
            endcase
            duplicate_q <= duplicate;
        end
    end

endmodule

// File: tb/tb_retry_reorder_end.sv
// Directed self-checking bench for retry_reorder_end with 8-bit payloads and 4-bit IDs.
module tb_retry_reorder_end;

    logic clk;
    logic rstN;
    int   checkCount;
    int   failCount;
    int   expNext;

    retry_reorder_end_if #(.DataType(logic [7:0]), .IDSize(4)) bus ();

    retry_reorder_end #(
        .DataType (logic [7:0]),
        .IDSize   (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic needsRetry, input logic [3:0] id,
                                 input logic [7:0] data);
        bus.valid_i       = valid;
        bus.needs_retry_i = needsRetry;
        bus.id_i          = id;
        bus.data_i        = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic resetDut();
        rstN = 1'b0;
        idle();
        bus.ready_i       = 1'b1;
        bus.retry_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rstN       = 1'b0;
        idle();
        bus.ready_i       = 1'b1;
        bus.retry_ready_i = 1'b0;
        #1;
        checkOutput("rst_valid_o", 32'(bus.valid_o), 32'd0);
        checkOutput("rst_retry_valid", 32'(bus.retry_valid_o), 32'd0);
        checkOutput("rst_occupancy", 32'(bus.occupancy_o), 32'd0);
        checkOutput("rst_duplicate", 32'(bus.duplicate_o), 32'd0);
        resetDut();

        $display("[TB] in-order IDs 0..15");
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 1'b0, 4'(k), 8'hA0 + 8'(k));
            #1;
            checkOutput("inorder_ready", 32'(bus.ready_o), 32'd1);
            step();
            checkOutput("inorder_valid", 32'(bus.valid_o), 32'd1);
            checkOutput("inorder_data", 32'(bus.data_o), 32'hA0 + 32'(k));
            checkOutput("inorder_occ", 32'(bus.occupancy_o), 32'd1);
            checkOutput("inorder_retry", 32'(bus.retry_valid_o), 32'd0);
        end
        idle();
        step();
        checkOutput("inorder_drain_valid", 32'(bus.valid_o), 32'd0);
        checkOutput("inorder_drain_occ", 32'(bus.occupancy_o), 32'd0);

        $display("[TB] out-of-order IDs 2,1,0");
        resetDut();
        applyStimulus(1'b1, 1'b0, 4'd2, 8'hB2);
        step();
        checkOutput("ooo_valid_a", 32'(bus.valid_o), 32'd0);
        checkOutput("ooo_occ_a", 32'(bus.occupancy_o), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'd1, 8'hB1);
        step();
        checkOutput("ooo_valid_b", 32'(bus.valid_o), 32'd0);
        checkOutput("ooo_occ_b", 32'(bus.occupancy_o), 32'd2);
        applyStimulus(1'b1, 1'b0, 4'd0, 8'hB0);
        step();
        checkOutput("ooo_valid_c", 32'(bus.valid_o), 32'd1);
        checkOutput("ooo_data_0", 32'(bus.data_o), 32'hB0);
        checkOutput("ooo_occ_c", 32'(bus.occupancy_o), 32'd3);
        idle();
        step();
        checkOutput("ooo_data_1", 32'(bus.data_o), 32'hB1);
        checkOutput("ooo_occ_d", 32'(bus.occupancy_o), 32'd2);
        step();
        checkOutput("ooo_data_2", 32'(bus.data_o), 32'hB2);
        checkOutput("ooo_occ_e", 32'(bus.occupancy_o), 32'd1);
        step();
        checkOutput("ooo_valid_end", 32'(bus.valid_o), 32'd0);
        checkOutput("ooo_occ_f", 32'(bus.occupancy_o), 32'd0);

        $display("[TB] retry then in-order release");
        resetDut();
        applyStimulus(1'b1, 1'b1, 4'd0, 8'hEE);
        #1;
        checkOutput("retry_ready_empty", 32'(bus.ready_o), 32'd1);
        step();
        checkOutput("retry_valid_set", 32'(bus.retry_valid_o), 32'd1);
        checkOutput("retry_id_0", 32'(bus.retry_id_o), 32'd0);
        checkOutput("retry_no_output", 32'(bus.valid_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'd1, 8'hC1);
        #1;
        checkOutput("retry_good_ready", 32'(bus.ready_o), 32'd1);
        step();
        checkOutput("retry_hold_valid", 32'(bus.valid_o), 32'd0);
        checkOutput("retry_hold_occ", 32'(bus.occupancy_o), 32'd1);
        checkOutput("retry_still_pending", 32'(bus.retry_valid_o), 32'd1);
        checkOutput("retry_id_stable", 32'(bus.retry_id_o), 32'd0);
        idle();
        bus.retry_ready_i = 1'b1;
        step();
        checkOutput("retry_drained", 32'(bus.retry_valid_o), 32'd0);
        bus.retry_ready_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'd0, 8'hC0);
        step();
        checkOutput("retry_out_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("retry_out_0", 32'(bus.data_o), 32'hC0);
        checkOutput("retry_out_occ", 32'(bus.occupancy_o), 32'd2);
        idle();
        step();
        checkOutput("retry_out_1", 32'(bus.data_o), 32'hC1);
        step();
        checkOutput("retry_out_end", 32'(bus.valid_o), 32'd0);

        $display("[TB] retry back-pressure");
        resetDut();
        applyStimulus(1'b1, 1'b1, 4'd3, 8'h00);
        step();
        checkOutput("bp_first_valid", 32'(bus.retry_valid_o), 32'd1);
        checkOutput("bp_first_id", 32'(bus.retry_id_o), 32'd3);
        applyStimulus(1'b1, 1'b1, 4'd4, 8'h00);
        #1;
        checkOutput("bp_second_blocked", 32'(bus.ready_o), 32'd0);
        step();
        checkOutput("bp_hold_id", 32'(bus.retry_id_o), 32'd3);
        bus.retry_ready_i = 1'b1;
        #1;
        checkOutput("bp_ready_comb", 32'(bus.ready_o), 32'd1);
        step();
        checkOutput("bp_refill_valid", 32'(bus.retry_valid_o), 32'd1);
        checkOutput("bp_second_id", 32'(bus.retry_id_o), 32'd4);
        idle();
        step();
        checkOutput("bp_cleared", 32'(bus.retry_valid_o), 32'd0);
        bus.retry_ready_i = 1'b0;

        $display("[TB] duplicate and wrap");
        resetDut();
        applyStimulus(1'b1, 1'b0, 4'd5, 8'hD5);
        step();
        checkOutput("dup_first", 32'(bus.duplicate_o), 32'd0);
        checkOutput("dup_occ_a", 32'(bus.occupancy_o), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'd5, 8'h55);
        step();
        checkOutput("dup_pulse", 32'(bus.duplicate_o), 32'd1);
        checkOutput("dup_occ_b", 32'(bus.occupancy_o), 32'd1);
        idle();
        step();
        checkOutput("dup_pulse_end", 32'(bus.duplicate_o), 32'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 4'(k), 8'hE0 + 8'(k));
            step();
            checkOutput("dup_fill_data", 32'(bus.data_o), 32'hE0 + 32'(k));
        end
        idle();
        step();
        checkOutput("dup_kept_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("dup_kept_data", 32'(bus.data_o), 32'hD5);
        step();
        checkOutput("dup_drain_occ", 32'(bus.occupancy_o), 32'd0);

        expNext = 0;
        for (int p = 0; p < 20; p++) begin
            for (int h = 1; h >= 0; h--) begin
                applyStimulus(1'b1, 1'b0, 4'((6 + 2 * p + h) % 16), 8'(2 * p + h));
                step();
                if (bus.valid_o) begin
                    checkOutput("wrap_data", 32'(bus.data_o), 32'(expNext));
                    expNext++;
                end
            end
        end
        idle();
        repeat (3) begin
            step();
            if (bus.valid_o) begin
                checkOutput("wrap_data", 32'(bus.data_o), 32'(expNext));
                expNext++;
            end
        end
        checkOutput("wrap_count", 32'(expNext), 32'd40);
        checkOutput("wrap_occ", 32'(bus.occupancy_o), 32'd0);

        $display("[TB] reset mid-operation");
        resetDut();
        for (int k = 1; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 4'(k), 8'h10 + 8'(k));
            step();
        end
        applyStimulus(1'b1, 1'b1, 4'd0, 8'h00);
        step();
        checkOutput("mid_occ_before", 32'(bus.occupancy_o), 32'd3);
        checkOutput("mid_retry_before", 32'(bus.retry_valid_o), 32'd1);
        idle();
        rstN = 1'b0;
        #1;
        checkOutput("mid_valid_o", 32'(bus.valid_o), 32'd0);
        checkOutput("mid_retry_valid", 32'(bus.retry_valid_o), 32'd0);
        checkOutput("mid_occ", 32'(bus.occupancy_o), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd0, 8'hF0);
        step();
        checkOutput("mid_resume_valid", 32'(bus.valid_o), 32'd1);
        checkOutput("mid_resume_data", 32'(bus.data_o), 32'hF0);
        idle();
        step();
        checkOutput("mid_stale_gone", 32'(bus.valid_o), 32'd0);
        checkOutput("mid_final_occ", 32'(bus.occupancy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/retry_reorder_end.md
Name: retry_reorder_end

Overview:
- Downstream neighbour of time_DMR_end. Alternative to retry_end for consumers that need in-order delivery.
- Consumes detected data tagged with its ID and a needs_retry flag.
- Sends faulty IDs back to retry_start over the retry feedback channel.
- Buffers good results by ID and releases them strictly in ID order (the order retry_start issued them), hiding the reordering that retries cause.

Parameters:
- DataType, logic, payload type carried unchanged.
- IDSize, 4, width of the transaction ID. Buffer depth is 2**IDSize.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_i  in  $bits(DataType)  payload from time_DMR_end
- id_i  in  IDSize  ID of the payload
- needs_retry_i  in  1  payload faulty, must be retried
- valid_i  in  1  upstream valid
- ready_o  out  1  upstream ready
- data_o  out  $bits(DataType)  in-order payload
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- retry_id_o  out  IDSize  ID to retry
- retry_valid_o  out  1  retry request valid
- retry_ready_i  in  1  retry request accepted by retry_start
- duplicate_o  out  1  one-cycle pulse: good ID arrived for an already-filled slot
- occupancy_o  out  IDSize+1  number of filled slots

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (rst_ni).
- Reset values:
  - all slot valid bits 0; out_ptr 0 (matches the first ID of retry_start)
  - retry_valid_q 0, retry_id_q 0
  - valid_o 0, retry_valid_o 0, duplicate_o 0, occupancy_o 0
  - data_o undefined-but-stable (driven from storage)
- Storage: 2**IDSize entries of DataType plus one valid bit each, indexed by ID.
- Input, good (valid_i & !needs_retry_i):
  - ready_o=1 always.
  - If slot[id_i] is empty: write data, set the valid bit next edge.
  - If slot[id_i] is full: drop, no overwrite, duplicate_o=1 next cycle.
- Input, faulty (valid_i & needs_retry_i):
  - Data is discarded.
  - ready_o = !retry_valid_q | retry_ready_i.
  - On handshake: retry_valid_q<=1, retry_id_q<=id_i.
- Retry register: one-entry output register.
  - retry_valid_o=retry_valid_q, retry_id_o=retry_id_q.
  - Cleared on retry_ready_i unless refilled in the same cycle (the refill wins).
  - No combinational path from retry_ready_i to retry_valid_o.
  - Combinational path from retry_ready_i to ready_o is allowed.
- Output:
  - valid_o = slot_valid[out_ptr], data_o = slot[out_ptr].
  - On valid_o & ready_i: clear slot_valid[out_ptr]; out_ptr <= out_ptr+1, wrapping at 2**IDSize to 0.
  - No bypass: a store into slot out_ptr becomes visible one cycle later (minimum latency 1).
- Simultaneous events:
  - Pop of out_ptr and store to another slot in the same cycle: both take effect.
  - A store to out_ptr while it is being popped is impossible, since the slot is full; it counts as a duplicate.
- occupancy_o: +1 per accepted non-duplicate store, -1 per pop; both in the same cycle gives net 0.
- Liveness: retry_start never has more than 2**IDSize IDs in flight, so slots never alias. The block does not check this.
- AXI-style rules:
  - valid_o and retry_valid_o, once high, stay high with stable data until their handshake completes.
  - Reset mid-operation discards all buffered data and pending retries immediately.

Decomposition:
- Shared package retry_pkg: ID width helpers and a retry request struct {id}.
- The retry register is natural as sub-module retry_req_reg, a one-entry spill register with a valid/ready interface.
- Storage and reorder logic stay in the top module.

Test Plan:
- In order, no faults: IDs 0..15 with data 8'hA0+ID, ready_i=1.
  - Outputs are A0..AF in order, each one cycle after input.
  - retry_valid_o stays 0; occupancy_o ≤1.
- Out of order: IDs 2, 1, 0.
  - No valid_o until ID 0 is stored.
  - Then data for 0, 1, 2 on consecutive cycles; occupancy_o goes 1, 2, 3, 2, 1, 0.
- Retry, with retry_ready_i held 0: ID 0 needs_retry, then ID 1 good.
  - retry_valid_o=1, retry_id_o=0; ID 1 is held and valid_o=0.
  - Raise retry_ready_i, then send ID 0 good: outputs ID 0, then ID 1.
- Back-pressure on retries:
  - Two faulty IDs 3 and 4 back-to-back with retry_ready_i=0: the second sees ready_o=0.
  - Pulse retry_ready_i: retry IDs 3 then 4 are emitted in order.
- Duplicate and wrap:
  - Good ID 5 twice: duplicate_o pulses once, the stored data keeps its first value.
  - Run 40 transactions across the ID wrap 15→0: order is preserved.
- Reset mid-operation: assert rst_ni low with 3 buffered entries and a pending retry.
  - valid_o=0, retry_valid_o=0, occupancy_o=0 immediately.
  - Output resumes from ID 0 after reset.
